// File: rtl/pio_svc_pkg.sv
// rtl/pio_svc_pkg.sv - shared FSM states, PIO register map and counter helpers for pio_irq_servicer
package pio_svc_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_CAP,
      S_WAIT_CAP,
      S_CLR,
      S_RD_DAT,
      S_WAIT_DAT,
      S_EMIT
   } svc_state_t;

   localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
   localparam logic [1:0] PIO_ADDR_CAP  = 2'd3;

   localparam int SPUR_CNT_W = 8;

   function automatic logic [SPUR_CNT_W-1:0] sat_inc(input logic [SPUR_CNT_W-1:0] v);
      return (&v) ? v : v + SPUR_CNT_W'(1);
   endfunction

endpackage

// File: rtl/pio_irq_servicer_rr_arbiter.sv
// rtl/pio_irq_servicer_rr_arbiter.sv - combinational round-robin arbiter
// Grants the first requester strictly after the last-grant pointer, wrapping around.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_idx,
   output logic           gnt_valid
);

   logic [IDW-1:0] j;

   always_comb begin
      gnt       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      j         = '0;
      for (int k = 1; k <= N; k++) begin
         j = IDW'((int'(last) + k) % N);
         if (!gnt_valid && req[j]) begin
            gnt_valid = 1'b1;
            gnt[j]    = 1'b1;
            gnt_idx   = j;
         end
      end
   end

endmodule

// File: rtl/pio_irq_servicer.sv
// rtl/pio_irq_servicer.sv - round-robin servicer for edge-capture PIO interrupts
// Define PIO_SVC_DATA_SNAP_EN to add the addr-0 data snapshot after each clear.
module pio_irq_servicer
   import pio_svc_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int PIO_W   = 2,
   parameter int SRC_IDW = $clog2(NUM_SRC)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_SRC-1:0]      src_irq,
   input  logic [NUM_SRC-1:0]      src_en,
   output logic [NUM_SRC-1:0]      m_chipselect,
   output logic [1:0]              m_address,
   output logic                    m_write_n,
   output logic [31:0]             m_writedata,
   input  logic [NUM_SRC*32-1:0]   m_readdata,
   output logic                    evt_valid,
   input  logic                    evt_ready,
   output logic [SRC_IDW-1:0]      evt_src,
   output logic [PIO_W-1:0]        evt_edges,
   output logic [PIO_W-1:0]        evt_data,
   output logic [SPUR_CNT_W-1:0]   spurious_cnt,
   output logic                    busy
);

   svc_state_t          state;
   logic [SRC_IDW-1:0]  rr_ptr;
   logic [SRC_IDW-1:0]  gnt_idx;
   logic [NUM_SRC-1:0]  gnt_oh;
   logic [NUM_SRC-1:0]  pending;
   logic [NUM_SRC-1:0]  arb_gnt;
   logic [SRC_IDW-1:0]  arb_idx;
   logic                arb_valid;
   logic [PIO_W-1:0]    rd_low [NUM_SRC];
   logic [PIO_W-1:0]    rd_slice;
   logic                unused_rd;

   assign pending = src_irq & src_en;

   rr_arbiter #(
      .N   (NUM_SRC),
      .IDW (SRC_IDW)
   ) u_arb (
      .req       (pending),
      .last      (rr_ptr),
      .gnt       (arb_gnt),
      .gnt_idx   (arb_idx),
      .gnt_valid (arb_valid)
   );

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         rd_low[i] = m_readdata[i*32 +: PIO_W];
      end
   end

   // Only the low PIO_W bits of each slave word carry information.
   assign unused_rd = ^m_readdata;
   assign rd_slice  = rd_low[gnt_idx];
   assign gnt_oh    = NUM_SRC'(1) << gnt_idx;
   assign busy      = (state != S_IDLE);

`ifdef PIO_SVC_DATA_SNAP_EN
   logic [PIO_W-1:0] data_q;
   assign evt_data = data_q;
`else
   assign evt_data = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         rr_ptr       <= SRC_IDW'(NUM_SRC - 1);
         gnt_idx      <= '0;
         m_chipselect <= '0;
         m_address    <= PIO_ADDR_DATA;
         m_write_n    <= 1'b1;
         m_writedata  <= '0;
         evt_valid    <= 1'b0;
         evt_src      <= '0;
         evt_edges    <= '0;
         spurious_cnt <= '0;
`ifdef PIO_SVC_DATA_SNAP_EN
         data_q       <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (arb_valid) begin
                  gnt_idx      <= arb_idx;
                  m_chipselect <= arb_gnt;
                  m_address    <= PIO_ADDR_CAP;
                  m_write_n    <= 1'b1;
                  state        <= S_RD_CAP;
               end
            end
            S_RD_CAP: begin
               m_chipselect <= '0;
               state        <= S_WAIT_CAP;
            end
            S_WAIT_CAP: begin
               if (rd_slice == '0) begin
                  spurious_cnt <= sat_inc(spurious_cnt);
                  rr_ptr       <= gnt_idx;
                  state        <= S_IDLE;
               end else begin
                  evt_edges    <= rd_slice;
                  m_chipselect <= gnt_oh;
                  m_address    <= PIO_ADDR_CAP;
                  m_write_n    <= 1'b0;
                  m_writedata  <= {{(32-PIO_W){1'b0}}, rd_slice};
                  state        <= S_CLR;
               end
            end
            S_CLR: begin
               m_write_n <= 1'b1;
`ifdef PIO_SVC_DATA_SNAP_EN
               m_chipselect <= gnt_oh;
               m_address    <= PIO_ADDR_DATA;
               state        <= S_RD_DAT;
`else
               m_chipselect <= '0;
               evt_valid    <= 1'b1;
               evt_src      <= gnt_idx;
               state        <= S_EMIT;
`endif
            end
`ifdef PIO_SVC_DATA_SNAP_EN
            S_RD_DAT: begin
               m_chipselect <= '0;
               state        <= S_WAIT_DAT;
            end
            S_WAIT_DAT: begin
               data_q    <= rd_slice;
               evt_valid <= 1'b1;
               evt_src   <= gnt_idx;
               state     <= S_EMIT;
            end
`endif
            S_EMIT: begin
               // Bus stays quiet while stalled; new edges wait in the slaves.
               if (evt_ready) begin
                  evt_valid <= 1'b0;
                  rr_ptr    <= gnt_idx;
                  state     <= S_IDLE;
               end
            end
            default: begin
               m_chipselect <= '0;
               m_write_n    <= 1'b1;
               evt_valid    <= 1'b0;
               state        <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pio_irq_servicer.sv
// tb/tb_pio_irq_servicer.sv - self-checking bench for pio_irq_servicer with behavioural PIO slaves
// Honours PIO_SVC_DATA_SNAP_EN to pick the expected latency and data payload.
module tb_pio_irq_servicer;

   localparam int N   = 4;
   localparam int W   = 2;
   localparam int IDW = 2;
`ifdef PIO_SVC_DATA_SNAP_EN
   localparam bit SNAP = 1'b1;
`else
   localparam bit SNAP = 1'b0;
`endif
   localparam int LAT = SNAP ? 6 : 4;

   typedef struct {
      logic [IDW-1:0] src;
      logic [W-1:0]   edges;
      logic [W-1:0]   data;
   } ev_t;

   typedef struct {
      int           src;
      logic [W-1:0] cap;
      logic [W-1:0] dat;
      logic [W-1:0] exp_data;
      logic [31:0]  exp_wd;
   } vec_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [N-1:0]     src_irq;
   logic [N-1:0]     src_en = '1;
   logic [N-1:0]     m_chipselect;
   logic [1:0]       m_address;
   logic             m_write_n;
   logic [31:0]      m_writedata;
   logic [N*32-1:0]  m_readdata;
   logic             evt_valid;
   logic             evt_ready;
   logic [IDW-1:0]   evt_src;
   logic [W-1:0]     evt_edges;
   logic [W-1:0]     evt_data;
   logic [7:0]       spurious_cnt;
   logic             busy;

   pio_irq_servicer #(.NUM_SRC(N), .PIO_W(W), .SRC_IDW(IDW)) dut (
      .clk          (clk),
      .reset        (reset),
      .src_irq      (src_irq),
      .src_en       (src_en),
      .m_chipselect (m_chipselect),
      .m_address    (m_address),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata),
      .m_readdata   (m_readdata),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_src      (evt_src),
      .evt_edges    (evt_edges),
      .evt_data     (evt_data),
      .spurious_cnt (spurious_cnt),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // Behavioural PIO slaves: registered readdata, addr-3 write clears all capture bits.
   logic [W-1:0]  cap     [N] = '{default: '0};
   logic [W-1:0]  dat     [N] = '{default: '0};
   logic [W-1:0]  cap_val [N] = '{default: '0};
   logic [31:0]   rdq     [N] = '{default: '0};
   logic [N-1:0]  cap_load  = '0;
   logic [N-1:0]  force_irq = '0;
   int            wr_cnt = 0;

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (cap_load[i])
            cap[i] <= cap_val[i];
         else if (m_chipselect[i] && !m_write_n && m_address == 2'd3)
            cap[i] <= '0;
         case (m_address)
            2'd0:    rdq[i] <= {30'h2AAAAAAA, dat[i]};
            2'd3:    rdq[i] <= {30'h15555555, cap[i]};
            default: rdq[i] <= 32'hFFFFFFFF;
         endcase
      end
      if ((|m_chipselect) && !m_write_n) wr_cnt <= wr_cnt + 1;
   end

   always_comb begin
      m_readdata = '0;
      src_irq    = '0;
      for (int i = 0; i < N; i++) begin
         m_readdata[i*32 +: 32] = rdq[i];
         src_irq[i] = (cap[i] != '0) | force_irq[i];
      end
   end

   // Event consumer: drives ready just after each falling edge and logs handshakes.
   ev_t  ev_q[$];
   int   ready_pct = 100;
   int   stab_viol = 0;
   logic prev_stall = 1'b0;
   ev_t  prev_ev;

   initial begin
      evt_ready = 1'b0;
      forever begin
         @(negedge clk);
         #1;
         if (prev_stall && !reset) begin
            if (!evt_valid || evt_src !== prev_ev.src || evt_edges !== prev_ev.edges ||
                evt_data !== prev_ev.data)
               stab_viol++;
         end
         evt_ready = (int'($urandom_range(0, 99)) < ready_pct);
         if (evt_valid && evt_ready)
            ev_q.push_back('{src: evt_src, edges: evt_edges, data: evt_data});
         prev_stall = evt_valid && !evt_ready;
         prev_ev    = '{src: evt_src, edges: evt_edges, data: evt_data};
      end
   end

   int checks = 0;
   int failures = 0;
   int ev_rd = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic load_mask(input logic [N-1:0] m);
      cap_load = m;
      step(1);
      cap_load = '0;
   endtask

   task automatic load_one(input int s, input logic [W-1:0] v);
      cap_val[s] = v;
      load_mask(N'(1) << s);
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (!evt_valid && k < 30) begin step(1); k++; end
      chk(name, 32'(evt_valid), 32'd1);
   endtask

   task automatic wait_events(input string name, input int n, input int budget);
      int k = 0;
      while (ev_q.size() - ev_rd < n && k < budget) begin step(1); k++; end
      chk(name, ev_q.size() - ev_rd, n);
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((busy || (|src_irq)) && k < 500) begin step(1); k++; end
      chk("idle_reached", 32'(k < 500), 32'd1);
   endtask

   task automatic next_ev(output ev_t e);
      if (ev_rd < ev_q.size()) begin
         e = ev_q[ev_rd];
         ev_rd++;
      end else begin
         e = '{src: '1, edges: 'x, data: 'x};
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t          tbl [4];
   ev_t           e;
   logic [N-1:0]  oh;
   logic [N-1:0]  m;
   int            w0;
   int            e0;
   int            k;
   int            model_ptr;
   int            exp_src[$];

   initial begin
      tbl[0] = '{src: 1, cap: 2'b01, dat: 2'b11, exp_data: SNAP ? 2'b11 : 2'b00, exp_wd: 32'h1};
      tbl[1] = '{src: 3, cap: 2'b10, dat: 2'b01, exp_data: SNAP ? 2'b01 : 2'b00, exp_wd: 32'h2};
      tbl[2] = '{src: 0, cap: 2'b11, dat: 2'b10, exp_data: SNAP ? 2'b10 : 2'b00, exp_wd: 32'h3};
      tbl[3] = '{src: 2, cap: 2'b01, dat: 2'b00, exp_data: 2'b00,                exp_wd: 32'h1};

      step(2);
      chk("rst_bus", {m_chipselect, m_address, m_write_n}, {4'b0000, 2'd0, 1'b1});
      chk("rst_evt", {evt_valid, evt_src, evt_edges, evt_data, busy}, '0);
      chk("rst_spur", spurious_cnt, 8'd0);
      reset = 1'b0;
      step(1);

      // Single-source services, one table row each.
      for (int i = 0; i < 4; i++) begin
         oh = N'(1) << tbl[i].src;
         dat[tbl[i].src] = tbl[i].dat;
         w0 = wr_cnt;
         load_one(tbl[i].src, tbl[i].cap);
         step(1);
         chk("rdcap_bus", {m_chipselect, m_address, m_write_n}, {oh, 2'd3, 1'b1});
         step(2);
         chk("clr_bus", {m_chipselect, m_address, m_write_n}, {oh, 2'd3, 1'b0});
         chk("clr_wdata", m_writedata, tbl[i].exp_wd);
         k = 3;
         while (!evt_valid && k < 20) begin step(1); k++; end
         chk("latency", k, LAT);
         wait_events("tbl_count", 1, 10);
         next_ev(e);
         chk("tbl_src", e.src, tbl[i].src);
         chk("tbl_edges", e.edges, tbl[i].cap);
         chk("tbl_data", e.data, tbl[i].exp_data);
         chk("tbl_writes", wr_cnt - w0, 1);
         wait_idle();
      end

      // Backpressure with a second source arriving during the stall.
      ready_pct = 0;
      load_one(0, 2'b11);
      wait_valid("bp_valid_up");
      for (int i = 0; i < 10; i++) begin
         if (i == 0) begin cap_val[1] = 2'b01; cap_load = 4'b0010; end
         if (i == 1) cap_load = '0;
         step(1);
         chk("bp_hold", {evt_valid, evt_src, evt_edges, m_chipselect, m_write_n, busy},
             {1'b1, 2'd0, 2'b11, 4'b0000, 1'b1, 1'b1});
      end
      e0 = ev_q.size();
      ready_pct = 100;
      step(2);
      chk("bp_drop", {evt_valid, 8'(ev_q.size() - e0)}, {1'b0, 8'd1});
      next_ev(e);
      chk("bp_event", {e.src, e.edges}, {2'd0, 2'b11});
      wait_events("bp_next", 1, 20);
      next_ev(e);
      chk("bp_pending_src", {e.src, e.edges}, {2'd1, 2'b01});
      wait_idle();

      // Spurious services: irq with an empty capture register.
      w0 = wr_cnt;
      e0 = ev_q.size();
      force_irq = 4'b0100;
      k = 0;
      while (spurious_cnt == 8'd0 && k < 20) begin step(1); k++; end
      force_irq = '0;
      chk("spur_one", spurious_cnt, 8'd1);
      step(5);
      chk("spur_one_hold", spurious_cnt, 8'd1);
      force_irq = 4'b0100;
      step(1000);
      force_irq = '0;
      step(5);
      chk("spur_sat", spurious_cnt, 8'd255);
      chk("spur_no_write", wr_cnt - w0, 0);
      chk("spur_no_event", ev_q.size() - e0, 0);

      // Masking: source 2 waits until its enable returns.
      src_en = 4'b1011;
      cap_val[2] = 2'b01;
      cap_val[3] = 2'b10;
      load_mask(4'b1100);
      step(30);
      chk("mask_count", ev_q.size() - ev_rd, 1);
      next_ev(e);
      chk("mask_src3", {e.src, e.edges}, {2'd3, 2'b10});
      src_en = 4'b1111;
      wait_events("mask_late", 1, 30);
      next_ev(e);
      chk("mask_src2", {e.src, e.edges}, {2'd2, 2'b01});
      wait_idle();

      // Reset while an event is stalled, then round-robin from source 0.
      ready_pct = 0;
      load_one(2, 2'b10);
      wait_valid("rst_emit_valid");
      e0 = ev_q.size();
      reset = 1'b1;
      #1;
      chk("rst_async", {evt_valid, m_write_n, m_chipselect, busy}, {1'b0, 1'b1, 4'b0000, 1'b0});
      step(2);
      reset = 1'b0;
      ready_pct = 100;
      step(2);
      chk("rst_discard", ev_q.size() - e0, 0);
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++) cap_val[i] = 2'b01;
         load_mask(4'hF);
         wait_events("rr_count", 4, 100);
         for (int i = 0; i < N; i++) begin
            next_ev(e);
            chk("rr_order", e.src, i);
         end
         wait_idle();
      end

      // Randomised batches against a round-robin model.
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      model_ptr = N - 1;
      for (int b = 0; b < 30; b++) begin
         wait_idle();
         ready_pct = 20 + int'($urandom_range(0, 80));
         m = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            cap_val[i] = W'($urandom_range(1, 3));
            dat[i]     = W'($urandom_range(0, 3));
         end
         load_mask(m);
         exp_src.delete();
         for (int s = 1; s <= N; s++) begin
            if (m[(model_ptr + s) % N]) exp_src.push_back((model_ptr + s) % N);
         end
         model_ptr = exp_src[exp_src.size() - 1];
         wait_events("rand_count", exp_src.size(), 60 * N);
         foreach (exp_src[q]) begin
            next_ev(e);
            chk("rand_src", e.src, exp_src[q]);
            chk("rand_edges", e.edges, cap_val[exp_src[q]]);
            chk("rand_data", e.data, SNAP ? dat[exp_src[q]] : 2'b00);
         end
      end
      ready_pct = 100;
      wait_idle();
      chk("stall_stability", stab_viol, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
